// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter_if
// Description : Bus-ownership handshake between the CPU core, the UART DMA
//               controller and the arbiter that grants the shared BRAM bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_bus_arbiter_if;
    logic       i_Cpu_Busy;
    logic       o_Cpu_Grant;
    logic       i_Dma_Req;
    logic       o_Dma_Grant;
    logic       i_Dma_Ack;
    logic [1:0] o_Owner;
    logic       o_Timeout;
    logic [7:0] o_Xfer_Count;

    // Arbiter side
    modport slave (
        input  i_Cpu_Busy,
        input  i_Dma_Req,
        input  i_Dma_Ack,
        output o_Cpu_Grant,
        output o_Dma_Grant,
        output o_Owner,
        output o_Timeout,
        output o_Xfer_Count
    );

    // Requester side (CPU / DMA / bench)
    modport master (
        output i_Cpu_Busy,
        output i_Dma_Req,
        output i_Dma_Ack,
        input  o_Cpu_Grant,
        input  o_Dma_Grant,
        input  o_Owner,
        input  o_Timeout,
        input  o_Xfer_Count
    );
endinterface
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter
// Description : Shares the BRAM bus between the CPU (default owner) and the
//               UART DMA. Dead cycle on each handoff, watchdog on the DMA
//               tenure, cooldown window of CPU time between DMA tenures.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter #(
    parameter int TIMEOUT_CYCLES  = 200,
    parameter int COOLDOWN_CYCLES = 4
) (
    input  wire logic          i_Clock,
    input  wire logic          i_Reset,
    dma_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_CPU    = 2'b00,
        S_TO_DMA = 2'b01,
        S_DMA    = 2'b10,
        S_TO_CPU = 2'b11
    } state_t;

    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_COOLDOWN  = 16'(COOLDOWN_CYCLES);

    state_t      r_state;
    logic [15:0] r_cooldown;
    logic [15:0] r_wdog;
    logic [7:0]  r_xfer_count;
    logic        r_cpu_grant;
    logic        r_dma_grant;
    logic        r_timeout;

    // The cooldown gate looks at the post-decrement value so that exactly
    // COOLDOWN_CYCLES cycles are spent in S_CPU before the next handoff
    // (and a zero cooldown still leaves S_CPU for a single cycle).
    logic w_cooldown_done;
    assign w_cooldown_done = (r_cooldown <= 16'd1);

    // Ownership FSM; grants, timeout and owner are registered with the state.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state      <= S_CPU;
            r_cooldown   <= '0;
            r_wdog       <= '0;
            r_xfer_count <= '0;
            r_cpu_grant  <= 1'b1;
            r_dma_grant  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_CPU: begin
                    if (r_cooldown != 16'd0) begin
                        r_cooldown <= r_cooldown - 16'd1;
                    end
                    if (bus.i_Dma_Req && !bus.i_Cpu_Busy && w_cooldown_done) begin
                        r_state     <= S_TO_DMA;
                        r_cpu_grant <= 1'b0;
                    end
                end
                S_TO_DMA: begin
                    r_wdog      <= '0;
                    r_state     <= S_DMA;
                    r_dma_grant <= 1'b1;
                end
                S_DMA: begin
                    r_wdog <= r_wdog + 16'd1;
                    // Ack wins over every other exit reason.
                    if (bus.i_Dma_Ack) begin
                        r_xfer_count <= r_xfer_count + 8'd1;
                        r_state      <= S_TO_CPU;
                        r_dma_grant  <= 1'b0;
                    end else if (!bus.i_Dma_Req) begin
                        r_state     <= S_TO_CPU;
                        r_dma_grant <= 1'b0;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_timeout   <= 1'b1;
                        r_state     <= S_TO_CPU;
                        r_dma_grant <= 1'b0;
                    end
                end
                default: begin // S_TO_CPU
                    r_cooldown  <= c_COOLDOWN;
                    r_state     <= S_CPU;
                    r_cpu_grant <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_Cpu_Grant  = r_cpu_grant;
    assign bus.o_Dma_Grant  = r_dma_grant;
    assign bus.o_Owner      = r_state;
    assign bus.o_Timeout    = r_timeout;
    assign bus.o_Xfer_Count = r_xfer_count;

endmodule
`default_nettype wire
